// File: rtl/io_cond_pkg.sv
// Shared types and default constants for the coin/self-test input conditioner.
package io_cond_pkg;

    // Defaults: 1 ms tick at 100 MHz, 5 ms debounce, 20 ms coin pulse.
    localparam int unsigned TICK_DIV_DEF      = 100000;
    localparam int unsigned DB_TICKS_DEF      = 5;
    localparam int unsigned STRETCH_TICKS_DEF = 20;

    typedef enum logic [2:0] {
        IDLE,
        DB_PRESS,
        ACTIVE,
        WAIT_REL,
        DB_REL
    } coin_state_t;

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/coin_input_conditioner_if.sv
// Raw switch inputs and conditioned active-low outputs between board and io_sound.
// COIN_COUNT_EN adds the 8-bit per-channel press counters.
interface coin_input_conditioner_if;

    logic       btn_coin_l;
    logic       btn_coin_r;
    logic       btn_coin_aux;
    logic       sw_selftest;
    logic       coin_l;
    logic       coin_r;
    logic       coin_aux;
    logic       SELFTEST_b;
`ifdef COIN_COUNT_EN
    logic [7:0] coin_cnt_l;
    logic [7:0] coin_cnt_r;
    logic [7:0] coin_cnt_aux;
`endif

    // Board / stimulus side.
    modport master (
        output btn_coin_l, btn_coin_r, btn_coin_aux, sw_selftest,
`ifdef COIN_COUNT_EN
        input  coin_cnt_l, coin_cnt_r, coin_cnt_aux,
`endif
        input  coin_l, coin_r, coin_aux, SELFTEST_b
    );

    // Conditioner side.
    modport slave (
        input  btn_coin_l, btn_coin_r, btn_coin_aux, sw_selftest,
`ifdef COIN_COUNT_EN
        output coin_cnt_l, coin_cnt_r, coin_cnt_aux,
`endif
        output coin_l, coin_r, coin_aux, SELFTEST_b
    );

endinterface

// File: rtl/coin_channel.sv
// One coin channel: 2-flop synchroniser, tick debounce and fixed-width low pulse.
// COIN_COUNT_EN adds an 8-bit count of accepted presses.
module coin_channel
    import io_cond_pkg::*;
#(
    parameter int unsigned DB_TICKS      = DB_TICKS_DEF,
    parameter int unsigned STRETCH_TICKS = STRETCH_TICKS_DEF,
    parameter int unsigned CNT_W         = 8
) (
    input  logic       clk100,
    input  logic       rst_b,
    input  logic       tick,
    input  logic       btn,
`ifdef COIN_COUNT_EN
    output logic [7:0] coin_cnt,
`endif
    output logic       coin_b
);

    localparam logic [CNT_W-1:0] DB_LAST      = CNT_W'(DB_TICKS - 1);
    localparam logic [CNT_W-1:0] STRETCH_LAST = CNT_W'(STRETCH_TICKS - 1);

    logic             sync1_q, sync2_q;
    coin_state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             out_q;

    // Two-flop synchroniser for the asynchronous switch.
    always_ff @(posedge clk100) begin
        if (!rst_b) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= btn;
            sync2_q <= sync1_q;
        end
    end

    // State, tick counter and registered output (output lags state by one cycle).
    always_ff @(posedge clk100) begin
        if (!rst_b) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            out_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            out_q   <= (state_q != ACTIVE);
        end
    end

    // Next-state logic; a level change in a debounce state beats a same-cycle tick.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (sync2_q) begin
                    state_d = DB_PRESS;
                    cnt_d   = '0;
                end
            end
            DB_PRESS: begin
                if (!sync2_q) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (tick) begin
                    if (cnt_q == DB_LAST) begin
                        state_d = ACTIVE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            ACTIVE: begin
                if (tick) begin
                    if (cnt_q == STRETCH_LAST) begin
                        state_d = WAIT_REL;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            WAIT_REL: begin
                if (!sync2_q) begin
                    state_d = DB_REL;
                    cnt_d   = '0;
                end
            end
            DB_REL: begin
                if (sync2_q) begin
                    state_d = WAIT_REL;
                    cnt_d   = '0;
                end else if (tick) begin
                    if (cnt_q == DB_LAST) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign coin_b = out_q;

`ifdef COIN_COUNT_EN
    logic [7:0] coin_cnt_q;

    // Count accepted presses; wraps naturally at 255.
    always_ff @(posedge clk100) begin
        if (!rst_b) begin
            coin_cnt_q <= 8'd0;
        end else if (state_d == ACTIVE && state_q != ACTIVE) begin
            coin_cnt_q <= coin_cnt_q + 8'd1;
        end
    end

    assign coin_cnt = coin_cnt_q;
`endif

endmodule

// File: rtl/coin_input_conditioner.sv
// Conditions raw coin and self-test switches into clean active-low signals for io_sound.
// Holds the shared tick generator and the self-test level debouncer.
// Define COIN_COUNT_EN to expose per-channel 8-bit press counters.
module coin_input_conditioner
    import io_cond_pkg::*;
#(
    parameter int unsigned TICK_DIV      = TICK_DIV_DEF,
    parameter int unsigned DB_TICKS      = DB_TICKS_DEF,
    parameter int unsigned STRETCH_TICKS = STRETCH_TICKS_DEF
) (
    input  logic                    clk100,
    input  logic                    rst_b,
    coin_input_conditioner_if.slave bus
);

    localparam int unsigned      CNT_W     = $clog2(max3(TICK_DIV, DB_TICKS, STRETCH_TICKS) + 1);
    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DB_TICKS - 1);

    logic [CNT_W-1:0] tick_cnt_q;
    logic             tick;

    logic             st_sync1_q, st_sync2_q;
    logic             st_level_q, st_level_d;
    logic [CNT_W-1:0] st_cnt_q, st_cnt_d;

    logic             coin_l_b, coin_r_b, coin_aux_b;

    assign tick = (tick_cnt_q == TICK_LAST);

    // Free-running tick divider; first tick lands TICK_DIV cycles after reset.
    always_ff @(posedge clk100) begin
        if (!rst_b) begin
            tick_cnt_q <= '0;
        end else if (tick) begin
            tick_cnt_q <= '0;
        end else begin
            tick_cnt_q <= tick_cnt_q + CNT_W'(1);
        end
    end

    // Self-test synchroniser, accepted level and disagreement counter.
    always_ff @(posedge clk100) begin
        if (!rst_b) begin
            st_sync1_q <= 1'b0;
            st_sync2_q <= 1'b0;
            st_level_q <= 1'b0;
            st_cnt_q   <= '0;
        end else begin
            st_sync1_q <= bus.sw_selftest;
            st_sync2_q <= st_sync1_q;
            st_level_q <= st_level_d;
            st_cnt_q   <= st_cnt_d;
        end
    end

    // Accept a new self-test level after DB_TICKS ticks of uninterrupted disagreement.
    always_comb begin
        st_level_d = st_level_q;
        st_cnt_d   = st_cnt_q;
        if (st_sync2_q == st_level_q) begin
            st_cnt_d = '0;
        end else if (tick) begin
            if (st_cnt_q == DB_LAST) begin
                st_level_d = st_sync2_q;
                st_cnt_d   = '0;
            end else begin
                st_cnt_d = st_cnt_q + CNT_W'(1);
            end
        end
    end

    assign bus.SELFTEST_b = ~st_level_q;

    coin_channel #(
        .DB_TICKS      (DB_TICKS),
        .STRETCH_TICKS (STRETCH_TICKS),
        .CNT_W         (CNT_W)
    ) u_coin_l (
        .clk100   (clk100),
        .rst_b    (rst_b),
        .tick     (tick),
        .btn      (bus.btn_coin_l),
`ifdef COIN_COUNT_EN
        .coin_cnt (bus.coin_cnt_l),
`endif
        .coin_b   (coin_l_b)
    );

    coin_channel #(
        .DB_TICKS      (DB_TICKS),
        .STRETCH_TICKS (STRETCH_TICKS),
        .CNT_W         (CNT_W)
    ) u_coin_r (
        .clk100   (clk100),
        .rst_b    (rst_b),
        .tick     (tick),
        .btn      (bus.btn_coin_r),
`ifdef COIN_COUNT_EN
        .coin_cnt (bus.coin_cnt_r),
`endif
        .coin_b   (coin_r_b)
    );

    coin_channel #(
        .DB_TICKS      (DB_TICKS),
        .STRETCH_TICKS (STRETCH_TICKS),
        .CNT_W         (CNT_W)
    ) u_coin_aux (
        .clk100   (clk100),
        .rst_b    (rst_b),
        .tick     (tick),
        .btn      (bus.btn_coin_aux),
`ifdef COIN_COUNT_EN
        .coin_cnt (bus.coin_cnt_aux),
`endif
        .coin_b   (coin_aux_b)
    );

    assign bus.coin_l   = coin_l_b;
    assign bus.coin_r   = coin_r_b;
    assign bus.coin_aux = coin_aux_b;

endmodule
